// File: rtl/cordic_preproc_hs.sv
// rtl/cordic_preproc_hs.sv - CORDIC coarse +/-90 degree pre-rotation with 2-entry skid handshake
module cordic_preproc_hs #(
    parameter int XY_W    = 16,
    parameter int XYI     = 19,
    parameter int ANGLE_W = 32,
    parameter int TAG_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode_in,
    input  logic [XY_W-1:0]      x_in,
    input  logic [XY_W-1:0]      y_in,
    input  logic [ANGLE_W-1:0]   angle_in,
    input  logic [TAG_W-1:0]     tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XYI:0]         x0,
    output logic [XYI:0]         y0,
    output logic [ANGLE_W-1:0]   z0,
    output logic [1:0]           quad_o,
    output logic                 mode_o,
    output logic [TAG_W-1:0]     tag_o
);
    localparam int DW    = XYI + 1;
    localparam int Z_LO  = 2 * DW;
    localparam int Q_LO  = Z_LO + ANGLE_W;
    localparam int T_LO  = Q_LO + 2;
    localparam int M_POS = T_LO + TAG_W;
    localparam int PW    = M_POS + 1;
    localparam logic [ANGLE_W-1:0] HALF_PI = {2'b01, {(ANGLE_W-2){1'b0}}};

    generate
        if (XYI < XY_W) begin : g_bad_xyi
            $error("cordic_preproc_hs: XYI must be >= XY_W");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("cordic_preproc_hs: TAG_W must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    logic [DW-1:0]      w_x_ext, w_y_ext, w_x0, w_y0;
    logic [ANGLE_W-1:0] w_z;
    logic [1:0]         w_quad;
    logic [PW-1:0]      w_in_pl;
    logic               w_accept;

    state_t             r_state;
    logic               r_out_valid;
    logic               r_in_ready;
    logic [PW-1:0]      r_out_pl;
    logic [PW-1:0]      r_skid_pl;

    // Extend before negating so -(-2^(XY_W-1)) is representable.
    assign w_x_ext = {{(DW-XY_W){x_in[XY_W-1]}}, x_in};
    assign w_y_ext = {{(DW-XY_W){y_in[XY_W-1]}}, y_in};

    always_comb begin
        w_x0   = w_x_ext;
        w_y0   = w_y_ext;
        w_z    = angle_in;
        w_quad = 2'b00;
        if ((!mode_in && angle_in[ANGLE_W-1:ANGLE_W-2] == 2'b01) ||
            (mode_in && x_in[XY_W-1] && y_in[XY_W-1])) begin
            w_x0   = -w_y_ext;
            w_y0   = w_x_ext;
            w_z    = angle_in - HALF_PI;
            w_quad = 2'b01;
        end else if ((!mode_in && angle_in[ANGLE_W-1:ANGLE_W-2] == 2'b10) ||
                     (mode_in && x_in[XY_W-1] && !y_in[XY_W-1])) begin
            w_x0   = w_y_ext;
            w_y0   = -w_x_ext;
            w_z    = angle_in + HALF_PI;
            w_quad = 2'b10;
        end
    end

    assign w_in_pl  = {mode_in, tag_in, w_quad, w_z, w_y0, w_x0};
    assign w_accept = in_valid & r_in_ready;

    // in_ready is registered and only falls when the skid register fills.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_pl    <= '0;
            r_skid_pl   <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_out_pl    <= w_in_pl;
                        r_out_valid <= 1'b1;
                        r_state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept && !out_ready) begin
                        r_skid_pl  <= w_in_pl;
                        r_in_ready <= 1'b0;
                        r_state    <= S_FULL;
                    end else if (w_accept) begin
                        r_out_pl <= w_in_pl;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        r_out_pl   <= r_skid_pl;
                        r_in_ready <= 1'b1;
                        r_state    <= S_ONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign x0        = r_out_pl[DW-1:0];
    assign y0        = r_out_pl[Z_LO-1:DW];
    assign z0        = r_out_pl[Q_LO-1:Z_LO];
    assign quad_o    = r_out_pl[T_LO-1:Q_LO];
    assign tag_o     = r_out_pl[M_POS-1:T_LO];
    assign mode_o    = r_out_pl[M_POS];
endmodule

// File: tb/tb_cordic_preproc_hs.sv
// tb/tb_cordic_preproc_hs.sv - scoreboard bench for cordic_preproc_hs
module tb_cordic_preproc_hs;
    typedef struct packed {
        logic [19:0] x;
        logic [19:0] y;
        logic [31:0] z;
        logic [1:0]  q;
        logic        m;
        logic [7:0]  tag;
    } res_t;

    typedef struct {
        logic        m;
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] a;
        logic [7:0]  tag;
        res_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mode_in = 1'b0;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic [31:0] angle_in = '0;
    logic [7:0]  tag_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [19:0] x0, y0;
    logic [31:0] z0;
    logic [1:0]  quad_o;
    logic        mode_o;
    logic [7:0]  tag_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    res_t exp_cur;
    res_t exp_q[$];
    int   pop_cyc[$];

    cordic_preproc_hs #(.XY_W(16), .XYI(19), .ANGLE_W(32), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode_in(mode_in), .x_in(x_in), .y_in(y_in), .angle_in(angle_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x0(x0), .y0(y0), .z0(z0), .quad_o(quad_o), .mode_o(mode_o), .tag_o(tag_o)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic m, input logic [15:0] x, input logic [15:0] y,
                                   input logic [31:0] a, input logic [7:0] t);
        int xi, yi, ox, oy;
        logic [1:0] aq;
        res_t r;
        xi = int'($signed(x));
        yi = int'($signed(y));
        aq = a[31:30];
        ox = xi; oy = yi;
        r.z = a; r.q = 2'b00;
        if ((!m && aq == 2'b01) || (m && xi < 0 && yi < 0)) begin
            ox = -yi; oy = xi; r.z = a - 32'h4000_0000; r.q = 2'b01;
        end else if ((!m && aq == 2'b10) || (m && xi < 0 && yi >= 0)) begin
            ox = yi; oy = -xi; r.z = a + 32'h4000_0000; r.q = 2'b10;
        end
        r.x = 20'(ox);
        r.y = 20'(oy);
        r.m = m;
        r.tag = t;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Output compare happens before enqueueing this cycle's accepted input.
    always @(negedge clk) begin
        res_t e, got;
        cyc++;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                checks++;
                got = {x0, y0, z0, quad_o, mode_o, tag_o};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none", got);
                end else begin
                    e = exp_q.pop_front();
                    pop_cyc.push_back(cyc);
                    if (got !== e) begin
                        errors++;
                        $display("FAIL output: got %0h expected %0h", got, e);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(exp_cur);
        end
    end

    task automatic drive(input logic m, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] a, input logic [7:0] t, input res_t e);
        in_valid = 1'b1; mode_in = m; x_in = x; y_in = y; angle_in = a; tag_in = t;
        exp_cur = e;
    endtask

    task automatic send(input logic m, input logic [15:0] x, input logic [15:0] y,
                        input logic [31:0] a, input logic [7:0] t, input res_t e);
        int n = 0;
        drive(m, x, y, a, t, e);
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        vec_t tbl[9];
        logic [83:0] snap;
        int n0;
        res_t e;
        logic [15:0] rx, ry;
        logic [31:0] ra;
        logic rm;

        tbl[0] = '{1'b0, 16'd1000, 16'd0, 32'h6000_0000, 8'h01,
                   '{20'h00000, 20'd1000, 32'h2000_0000, 2'b01, 1'b0, 8'h01}};
        tbl[1] = '{1'b0, 16'd0, 16'h8000, 32'hA000_0000, 8'h02,
                   '{20'hF8000, 20'h00000, 32'hE000_0000, 2'b10, 1'b0, 8'h02}};
        tbl[2] = '{1'b0, 16'd0, 16'h8000, 32'h4000_0000, 8'h03,
                   '{20'h08000, 20'h00000, 32'h0000_0000, 2'b01, 1'b0, 8'h03}};
        tbl[3] = '{1'b1, 16'hFFFB, 16'd3, 32'h0, 8'h04,
                   '{20'd3, 20'd5, 32'h4000_0000, 2'b10, 1'b1, 8'h04}};
        tbl[4] = '{1'b1, 16'hFFFB, 16'hFFFD, 32'h0, 8'h05,
                   '{20'd3, 20'hFFFFB, 32'hC000_0000, 2'b01, 1'b1, 8'h05}};
        tbl[5] = '{1'b1, 16'd5, 16'hFFFD, 32'h0, 8'h06,
                   '{20'd5, 20'hFFFFD, 32'h0000_0000, 2'b00, 1'b1, 8'h06}};
        tbl[6] = '{1'b0, 16'hFFF9, 16'd9, 32'hC000_0000, 8'h07,
                   '{20'hFFFF9, 20'd9, 32'hC000_0000, 2'b00, 1'b0, 8'h07}};
        tbl[7] = '{1'b0, 16'h8000, 16'd100, 32'h8000_0000, 8'h08,
                   '{20'd100, 20'h08000, 32'hC000_0000, 2'b10, 1'b0, 8'h08}};
        tbl[8] = '{1'b1, 16'h8000, 16'h8000, 32'h7000_0000, 8'h09,
                   '{20'h08000, 20'hF8000, 32'h3000_0000, 2'b01, 1'b1, 8'h09}};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_outputs", {x0, y0, z0, quad_o, mode_o, tag_o}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_release", in_ready, 1);

        for (int i = 0; i < 9; i++) begin
            send(tbl[i].m, tbl[i].x, tbl[i].y, tbl[i].a, tbl[i].tag, tbl[i].exp);
            check("latency_1", out_valid, 1);
        end
        drain();

        // Backpressure: fill both entries, stall, then release in order.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(0, 16'd11, 16'd22, 32'h5000_0000, 8'd1, model(0, 16'd11, 16'd22, 32'h5000_0000, 8'd1));
        @(posedge clk); #1;
        drive(1, 16'hFFF0, 16'd7, 32'h0, 8'd2, model(1, 16'hFFF0, 16'd7, 32'h0, 8'd2));
        @(posedge clk); #1;
        drive(0, 16'd3, 16'hFF00, 32'h9000_0000, 8'd3, model(0, 16'd3, 16'hFF00, 32'h9000_0000, 8'd3));
        check("bp_in_ready_low", in_ready, 0);
        check("bp_tag_head", tag_o, 1);
        snap = {out_valid, x0, y0, z0, quad_o, mode_o, tag_o};
        @(posedge clk); #1;
        check("bp_stable", {out_valid, x0, y0, z0, quad_o, mode_o, tag_o}, snap);
        check("bp_in_ready_still_low", in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_reopen", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();

        // Streaming: 16 back-to-back random transactions.
        n0 = pop_cyc.size();
        for (int i = 0; i < 16; i++) begin
            rm = 1'($urandom_range(0, 1));
            rx = 16'($urandom); ry = 16'($urandom); ra = $urandom;
            e = model(rm, rx, ry, ra, 8'(8'h40 + i));
            send(rm, rx, ry, ra, 8'(8'h40 + i), e);
        end
        drain();
        check("stream_count", pop_cyc.size() - n0, 16);
        if (pop_cyc.size() - n0 == 16)
            check("stream_consecutive", pop_cyc[n0 + 15] - pop_cyc[n0], 15);

        // Reset while FULL: held data must vanish.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(0, 16'd1, 16'd2, 32'h0, 8'hA1, model(0, 16'd1, 16'd2, 32'h0, 8'hA1));
        @(posedge clk); #1;
        drive(0, 16'd3, 16'd4, 32'h0, 8'hA2, model(0, 16'd3, 16'd4, 32'h0, 8'hA2));
        @(posedge clk); #1;
        check("full_before_reset", in_ready, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        exp_q.delete();
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready_release", in_ready, 1);
        check("midrst_no_stale", out_valid, 0);
        repeat (5) @(posedge clk);
        #1;
        send(tbl[4].m, tbl[4].x, tbl[4].y, tbl[4].a, tbl[4].tag, tbl[4].exp);
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
